writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 99 +++++++++
 tb/tb_writeback_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the MEM/WB pipeline result with a FIFO of
// long-latency completions, forcing the FIFO to win after a bounded starvation period.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_p_valid,
    input  logic [4:0]                   in_p_rd,
    input  logic [31:0]                  in_p_data,
    output logic                         out_p_stall,
    input  logic                         in_m_valid,
    input  logic [4:0]                   in_m_rd,
    input  logic [31:0]                  in_m_data,
    output logic                         out_m_ready,
    output logic                         out_write_enable,
    output logic [4:0]                   out_write_reg,
    output logic [31:0]                  out_write_data,
    output logic [$clog2(DEPTH+1)-1:0]   out_fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [SW-1:0] r_starve;

    logic w_empty;
    logic w_force;
    logic w_pop;
    logic w_push;
    logic w_pipe_grant;

    // Everything is gated by reset so that nothing is granted or accepted in a reset cycle.
    assign w_empty      = (out_fifo_count == '0);
    assign w_force      = reset && (r_starve == STARVE_MAX) && !w_empty;
    assign w_pop        = w_force || (reset && !in_p_valid && !w_empty);
    assign w_pipe_grant = reset && in_p_valid && !w_force;
    assign out_p_stall  = w_force && in_p_valid;
    assign out_m_ready  = reset && (out_fifo_count < FULL_COUNT);
    assign w_push       = in_m_valid && out_m_ready && (in_m_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= in_m_rd;
            r_fifo_data[r_wr_ptr] <= in_m_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_write_enable <= 1'b0;
            out_write_reg    <= 5'd0;
            out_write_data   <= 32'd0;
            out_fifo_count   <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_starve         <= '0;
        end else begin
            if (w_pop) begin
                out_write_enable <= 1'b1;
                out_write_reg    <= r_fifo_rd[r_rd_ptr];
                out_write_data   <= r_fifo_data[r_rd_ptr];
                r_rd_ptr         <= r_rd_ptr + PW'(1);
            end else if (w_pipe_grant && (in_p_rd != 5'd0)) begin
                out_write_enable <= 1'b1;
                out_write_reg    <= in_p_rd;
                out_write_data   <= in_p_data;
            end else begin
                out_write_enable <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   out_fifo_count <= out_fifo_count + CW'(1);
                2'b01:   out_fifo_count <= out_fifo_count - CW'(1);
                default: out_fifo_count <= out_fifo_count;
            endcase

            // Starvation is only counted while something is actually waiting in the FIFO.
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_MAX) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of the arbitration rules.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_p_valid;
    logic [4:0]    in_p_rd;
    logic [31:0]   in_p_data;
    logic          out_p_stall;
    logic          in_m_valid;
    logic [4:0]    in_m_rd;
    logic [31:0]   in_m_data;
    logic          out_m_ready;
    logic          out_write_enable;
    logic [4:0]    out_write_reg;
    logic [31:0]   out_write_data;
    logic [CW-1:0] out_fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending completions kept as plain queues.
    logic [4:0]  qRd[$];
    logic [31:0] qData[$];
    int          mStarve = 0;
    logic        mWe = 1'b0;
    logic [4:0]  mReg = 5'd0;
    logic [31:0] mData = 32'd0;
    logic        expStall, expReady, obsStall, obsReady;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_p_valid       (in_p_valid),
        .in_p_rd          (in_p_rd),
        .in_p_data        (in_p_data),
        .out_p_stall      (out_p_stall),
        .in_m_valid       (in_m_valid),
        .in_m_rd          (in_m_rd),
        .in_m_data        (in_m_data),
        .out_m_ready      (out_m_ready),
        .out_write_enable (out_write_enable),
        .out_write_reg    (out_write_reg),
        .out_write_data   (out_write_data),
        .out_fifo_count   (out_fifo_count)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, samples the combinational outputs mid-cycle, clocks the
    // DUT and advances the reference model; returns 1 ns after the rising edge.
    task automatic applyStimulus(input logic rstN, input logic pv, input logic [4:0] prd,
                                 input logic [31:0] pdata, input logic mv,
                                 input logic [4:0] mrd, input logic [31:0] mdata);
        int cnt;
        bit forceW;
        bit pop;
        reset      = rstN;
        in_p_valid = pv;
        in_p_rd    = prd;
        in_p_data  = pdata;
        in_m_valid = mv;
        in_m_rd    = mrd;
        in_m_data  = mdata;
        #2;
        obsStall = out_p_stall;
        obsReady = out_m_ready;
        cnt      = qRd.size();
        forceW   = (mStarve == LIMIT) && (cnt != 0);
        expStall = rstN && forceW && pv;
        expReady = rstN && (cnt < DEPTH);
        @(posedge clk);
        if (!rstN) begin
            qRd.delete();
            qData.delete();
            mStarve = 0;
            mWe     = 1'b0;
            mReg    = 5'd0;
            mData   = 32'd0;
        end else begin
            pop = forceW || (!pv && cnt != 0);
            if (pop) begin
                mWe   = 1'b1;
                mReg  = qRd.pop_front();
                mData = qData.pop_front();
            end else if (pv) begin
                mWe = (prd != 5'd0);
                if (prd != 5'd0) begin
                    mReg  = prd;
                    mData = pdata;
                end
            end else begin
                mWe = 1'b0;
            end
            if (mv && expReady && mrd != 5'd0) begin
                qRd.push_back(mrd);
                qData.push_back(mdata);
            end
            if (pop || cnt == 0) mStarve = 0;
            else if (mStarve < LIMIT) mStarve = mStarve + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                          5'($urandom), $urandom);
            checks++;
            if (obsStall !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_stall: got %b expected 0", obsStall);
            end
            checks++;
            if (obsReady !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_ready: got %b expected 0", obsReady);
            end
            checks++;
            if ({out_write_enable, out_write_reg, out_write_data} !== 38'd0) begin
                errors++;
                $display("[TB] FAIL reset_write: got we=%b reg=%0d data=%h expected zeros",
                         out_write_enable, out_write_reg, out_write_data);
            end
            checks++;
            if (out_fifo_count !== CW'(0)) begin
                errors++; $display("[TB] FAIL reset_count: got %0d expected 0", out_fifo_count);
            end
        end
    endtask

    task automatic test_pipeline();
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        checks++;
        if ({out_write_enable, out_write_reg, out_write_data} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
            errors++;
            $display("[TB] FAIL pipe_write: got we=%b reg=%0d data=%h expected we=1 reg=5 data=a5a5a5a5",
                     out_write_enable, out_write_reg, out_write_data);
        end
        applyStimulus(1'b1, 1'b0, 5'd9, 32'h11111111, 1'b0, 5'd0, 32'd0);
        checks++;
        if ({out_write_enable, out_write_reg, out_write_data} !== {1'b0, 5'd5, 32'hA5A5A5A5}) begin
            errors++;
            $display("[TB] FAIL idle_hold: got we=%b reg=%0d data=%h expected we=0 reg=5 data=a5a5a5a5",
                     out_write_enable, out_write_reg, out_write_data);
        end
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
        checks++;
        if (out_write_enable !== 1'b0) begin
            errors++; $display("[TB] FAIL pipe_x0: got we=%b expected 0", out_write_enable);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
            checks++;
            if (obsReady !== 1'b1) begin
                errors++; $display("[TB] FAIL drain_ready%0d: got %b expected 1", i, obsReady);
            end
            checks++;
            if (i == 1) begin
                if (out_write_enable !== 1'b0) begin
                    errors++; $display("[TB] FAIL drain_first: got we=%b expected 0", out_write_enable);
                end
            end else if ({out_write_enable, out_write_reg, out_write_data} !==
                         {1'b1, 5'(i - 1), 32'h100 + 32'(i - 1)}) begin
                errors++;
                $display("[TB] FAIL drain_order%0d: got we=%b reg=%0d data=%h expected we=1 reg=%0d",
                         i, out_write_enable, out_write_reg, out_write_data, i - 1);
            end
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++;
        if ({out_write_enable, out_write_reg, out_write_data, out_fifo_count} !==
            {1'b1, 5'd5, 32'h105, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL drain_last: got we=%b reg=%0d data=%h count=%0d expected we=1 reg=5 data=105 count=0",
                     out_write_enable, out_write_reg, out_write_data, out_fifo_count);
        end
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b1, 5'(i), 32'h200 + 32'(i));
            checks++;
            if (obsReady !== (i <= 4)) begin
                errors++; $display("[TB] FAIL fill_ready%0d: got %b expected %b", i, obsReady, (i <= 4));
            end
            checks++;
            if ({out_write_enable, out_write_reg} !== {1'b1, 5'(20 + i)}) begin
                errors++;
                $display("[TB] FAIL fill_pipe%0d: got we=%b reg=%0d expected we=1 reg=%0d",
                         i, out_write_enable, out_write_reg, 20 + i);
            end
        end
        checks++;
        if (out_fifo_count !== CW'(4)) begin
            errors++; $display("[TB] FAIL fill_count: got %0d expected 4", out_fifo_count);
        end
    endtask

    task automatic test_simultaneous();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++; $display("[TB] FAIL full_pop_ready: got %b expected 0", obsReady);
        end
        checks++;
        if ({out_write_enable, out_write_reg, out_write_data, out_fifo_count} !==
            {1'b1, 5'd1, 32'h201, CW'(3)}) begin
            errors++;
            $display("[TB] FAIL full_pop: got we=%b reg=%0d data=%h count=%0d expected we=1 reg=1 data=201 count=3",
                     out_write_enable, out_write_reg, out_write_data, out_fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999);
        checks++;
        if ({out_write_enable, out_fifo_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL midreset: got we=%b count=%0d expected we=0 count=0",
                     out_write_enable, out_fifo_count);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checks++;
            if ({out_write_enable, out_fifo_count} !== {1'b0, CW'(0)}) begin
                errors++;
                $display("[TB] FAIL stale_write%0d: got we=%b count=%0d expected we=0 count=0",
                         i, out_write_enable, out_fifo_count);
            end
        end
    endtask

    task automatic test_x0_completion();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        checks++;
        if (obsReady !== 1'b1) begin
            errors++; $display("[TB] FAIL x0_ready: got %b expected 1", obsReady);
        end
        checks++;
        if ({out_write_enable, out_fifo_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL x0_discard: got we=%b count=%0d expected we=0 count=0",
                     out_write_enable, out_fifo_count);
        end
        applyStimulus(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hBEEF);
        checks++;
        if ({out_write_enable, out_write_reg, out_fifo_count} !== {1'b1, 5'd6, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL x0_with_pipe: got we=%b reg=%0d count=%0d expected we=1 reg=6 count=0",
                     out_write_enable, out_write_reg, out_fifo_count);
        end
    endtask

    task automatic test_starve();
        applyStimulus(1'b1, 1'b1, 5'd11, 32'hB00, 1'b1, 5'd7, 32'h777);
        checks++;
        if ({out_write_enable, out_write_reg, out_fifo_count} !== {1'b1, 5'd11, CW'(1)}) begin
            errors++;
            $display("[TB] FAIL starve_setup: got we=%b reg=%0d count=%0d expected we=1 reg=11 count=1",
                     out_write_enable, out_write_reg, out_fifo_count);
        end
        for (int k = 1; k <= LIMIT; k++) begin
            applyStimulus(1'b1, 1'b1, 5'(11 + k), 32'hB00 + 32'(k), 1'b0, 5'd0, 32'd0);
            checks++;
            if ({obsStall, out_write_enable, out_write_reg} !== {1'b0, 1'b1, 5'(11 + k)}) begin
                errors++;
                $display("[TB] FAIL starve_pipe%0d: got stall=%b we=%b reg=%0d expected stall=0 we=1 reg=%0d",
                         k, obsStall, out_write_enable, out_write_reg, 11 + k);
            end
        end
        applyStimulus(1'b1, 1'b1, 5'd30, 32'h3030, 1'b0, 5'd0, 32'd0);
        checks++;
        if ({obsStall, out_write_enable, out_write_reg, out_write_data, out_fifo_count} !==
            {1'b1, 1'b1, 5'd7, 32'h777, CW'(0)}) begin
            errors++;
            $display("[TB] FAIL starve_force: got stall=%b we=%b reg=%0d data=%h count=%0d expected stall=1 we=1 reg=7 data=777 count=0",
                     obsStall, out_write_enable, out_write_reg, out_write_data, out_fifo_count);
        end
        applyStimulus(1'b1, 1'b1, 5'd30, 32'h3030, 1'b0, 5'd0, 32'd0);
        checks++;
        if ({obsStall, out_write_enable, out_write_reg, out_write_data} !==
            {1'b0, 1'b1, 5'd30, 32'h3030}) begin
            errors++;
            $display("[TB] FAIL starve_delayed: got stall=%b we=%b reg=%0d data=%h expected stall=0 we=1 reg=30 data=3030",
                     obsStall, out_write_enable, out_write_reg, out_write_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic rstN, pv, mv;
            logic [4:0] prd, mrd;
            rstN = ($urandom_range(0, 99) >= 2);
            pv   = ($urandom_range(0, 99) < 75);
            mv   = ($urandom_range(0, 99) < 60);
            prd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(rstN, pv, prd, $urandom, mv, mrd, $urandom);
            checks++;
            if (obsStall !== expStall) begin
                errors++; $display("[TB] FAIL rand_stall cyc%0d: got %b expected %b", i, obsStall, expStall);
            end
            checks++;
            if (obsReady !== expReady) begin
                errors++; $display("[TB] FAIL rand_ready cyc%0d: got %b expected %b", i, obsReady, expReady);
            end
            checks++;
            if (out_write_enable !== mWe) begin
                errors++; $display("[TB] FAIL rand_we cyc%0d: got %b expected %b", i, out_write_enable, mWe);
            end
            checks++;
            if (out_fifo_count !== CW'(qRd.size())) begin
                errors++;
                $display("[TB] FAIL rand_count cyc%0d: got %0d expected %0d", i, out_fifo_count, qRd.size());
            end
            if (mWe) begin
                checks++;
                if ({out_write_reg, out_write_data} !== {mReg, mData}) begin
                    errors++;
                    $display("[TB] FAIL rand_wdata cyc%0d: got reg=%0d data=%h expected reg=%0d data=%h",
                             i, out_write_reg, out_write_data, mReg, mData);
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_pipeline();
        test_fill();
        test_simultaneous();
        test_reset_mid();
        test_x0_completion();
        test_starve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
